// File: rtl/ntsc_chroma_seq.sv
// -----------------------------------------------------------------------------
// ntsc_chroma_seq
// 4fsc NTSC timing and chroma-modulation sequencer.
//
// Free-runs the horizontal sample counter and the line counter, derives the
// sync / burst / active flags from them, and keeps a free-running 2-bit
// subcarrier phase.  The active/burst/phase flags are delayed to line up with
// the U/V samples coming back from the RGB-to-YUV converter, and a final
// register stage produces the quadrature-modulated chroma sample, with the
// colour burst inserted on the -U axis.
//
// Ports
//   CK_i       4fsc clock
//   AR_i       asynchronous reset, active-high
//   EE_i       clock enable; every register advances only when 1
//   UUs_i      signed U from converter (valid C_PIPE_DLY enabled cycles
//              after the matching PIX_REQ_o)
//   VVs_i      signed V from converter
//   HCTRs_o    horizontal sample counter
//   VCTRs_o    line counter
//   PIX_REQ_o  pixel request to the converter (undelayed active flag)
//   HSYNC_o    horizontal sync, active-high, one cycle after the counters
//   VSYNC_o    vertical sync, active-high, one cycle after the counters
//   BURST_o    burst window, aligned with CCs_o
//   ACTIVE_o   active video, aligned with CCs_o
//   PHASE_o    subcarrier phase aligned with CCs_o (0:+U 1:+V 2:-U 3:-V)
//   CCs_o      signed modulated chroma
// -----------------------------------------------------------------------------
module ntsc_chroma_seq #(
   parameter int C_H_TOTAL   = 910,
   parameter int C_V_TOTAL   = 525,
   parameter int C_HSYNC_W   = 67,
   parameter int C_BURST_ST  = 76,
   parameter int C_BURST_W   = 36,
   parameter int C_ACT_ST    = 140,
   parameter int C_ACT_W     = 768,
   parameter int C_VSYNC_ST  = 3,
   parameter int C_VSYNC_H   = 3,
   parameter int C_VACT_ST   = 20,
   parameter int C_VACT_H    = 480,
   parameter int C_PIPE_DLY  = 2,
   parameter int C_BURST_AMP = 20
) (
   input  logic              CK_i,
   input  logic              AR_i,
   input  logic              EE_i,
   input  logic signed [7:0] UUs_i,
   input  logic signed [7:0] VVs_i,
   output logic        [9:0] HCTRs_o,
   output logic        [9:0] VCTRs_o,
   output logic              PIX_REQ_o,
   output logic              HSYNC_o,
   output logic              VSYNC_o,
   output logic              BURST_o,
   output logic              ACTIVE_o,
   output logic        [1:0] PHASE_o,
   output logic signed [7:0] CCs_o
);

   // Window bounds as 10-bit constants so every compare is width-matched.
   localparam logic [9:0] L_H_LAST   = 10'(C_H_TOTAL - 1);
   localparam logic [9:0] L_V_LAST   = 10'(C_V_TOTAL - 1);
   localparam logic [9:0] L_HSYNC_E  = 10'(C_HSYNC_W);
   localparam logic [9:0] L_BURST_S  = 10'(C_BURST_ST);
   localparam logic [9:0] L_BURST_E  = 10'(C_BURST_ST + C_BURST_W);
   localparam logic [9:0] L_ACT_S    = 10'(C_ACT_ST);
   localparam logic [9:0] L_ACT_E    = 10'(C_ACT_ST + C_ACT_W);
   localparam logic [9:0] L_VSYNC_S  = 10'(C_VSYNC_ST);
   localparam logic [9:0] L_VSYNC_E  = 10'(C_VSYNC_ST + C_VSYNC_H);
   localparam logic [9:0] L_VACT_S   = 10'(C_VACT_ST);
   localparam logic [9:0] L_VACT_E   = 10'(C_VACT_ST + C_VACT_H);
   localparam logic signed [7:0] L_BAMP = 8'(C_BURST_AMP);

   // -------------------------------------------------------------------------
   // Counters
   // -------------------------------------------------------------------------
   logic [9:0] r_hctr;
   logic [9:0] r_vctr;
   logic [1:0] r_ph;     // free-running; never cleared by line/frame wrap

   logic w_hwrap;
   logic w_vwrap;

   assign w_hwrap = (r_hctr == L_H_LAST);
   assign w_vwrap = (r_vctr == L_V_LAST);

   always_ff @(posedge CK_i or posedge AR_i) begin
      if (AR_i) begin
         r_hctr <= '0;
         r_vctr <= '0;
         r_ph   <= '0;
      end else if (EE_i) begin
         r_ph <= r_ph + 2'd1;
         if (w_hwrap) begin
            r_hctr <= '0;
            r_vctr <= w_vwrap ? 10'd0 : r_vctr + 10'd1;
         end else begin
            r_hctr <= r_hctr + 10'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stage-0 flags, straight from the registered counters
   // -------------------------------------------------------------------------
   logic w_hs;
   logic w_vs;
   logic w_bu;
   logic w_ac;

   assign w_hs = (r_hctr < L_HSYNC_E);
   assign w_vs = (r_vctr >= L_VSYNC_S) && (r_vctr < L_VSYNC_E);
   // No burst on the vertical sync lines.
   assign w_bu = (r_hctr >= L_BURST_S) && (r_hctr < L_BURST_E) && !w_vs;
   assign w_ac = (r_hctr >= L_ACT_S) && (r_hctr < L_ACT_E) &&
                 (r_vctr >= L_VACT_S) && (r_vctr < L_VACT_E);

   assign PIX_REQ_o = w_ac;

   // -------------------------------------------------------------------------
   // Sync outputs: one register, no pipeline alignment needed
   // -------------------------------------------------------------------------
   logic r_hsync;
   logic r_vsync;

   always_ff @(posedge CK_i or posedge AR_i) begin
      if (AR_i) begin
         r_hsync <= 1'b0;
         r_vsync <= 1'b0;
      end else if (EE_i) begin
         r_hsync <= w_hs;
         r_vsync <= w_vs;
      end
   end

   // -------------------------------------------------------------------------
   // Alignment delay: matches the converter latency in enabled cycles so the
   // last tap describes the same pixel as UUs_i/VVs_i.
   // -------------------------------------------------------------------------
   logic [C_PIPE_DLY-1:0]      r_ac_d;
   logic [C_PIPE_DLY-1:0]      r_bu_d;
   logic [C_PIPE_DLY-1:0][1:0] r_ph_d;

   always_ff @(posedge CK_i or posedge AR_i) begin
      if (AR_i) begin
         r_ac_d <= '0;
         r_bu_d <= '0;
         r_ph_d <= '0;
      end else if (EE_i) begin
         r_ac_d[0] <= w_ac;
         r_bu_d[0] <= w_bu;
         r_ph_d[0] <= r_ph;
         for (int k = 1; k < C_PIPE_DLY; k++) begin
            r_ac_d[k] <= r_ac_d[k-1];
            r_bu_d[k] <= r_bu_d[k-1];
            r_ph_d[k] <= r_ph_d[k-1];
         end
      end
   end

   logic       w_ac_al;
   logic       w_bu_al;
   logic [1:0] w_ph_al;

   assign w_ac_al = r_ac_d[C_PIPE_DLY-1];
   assign w_bu_al = r_bu_d[C_PIPE_DLY-1];
   assign w_ph_al = r_ph_d[C_PIPE_DLY-1];

   // -------------------------------------------------------------------------
   // Chroma modulation
   // -------------------------------------------------------------------------
   // -(-128) does not fit in 8 bits; clamp it to +127.
   function automatic logic signed [7:0] f_neg_sat(input logic signed [7:0] x);
      if (x == 8'sh80) return 8'sh7F;
      return -x;
   endfunction

   logic signed [7:0] w_cc;

   always_comb begin
      w_cc = '0;
      if (w_ac_al) begin
         // Active wins if a mis-parameterised burst window overlaps it.
         unique case (w_ph_al)
            2'd0: w_cc = UUs_i;
            2'd1: w_cc = VVs_i;
            2'd2: w_cc = f_neg_sat(UUs_i);
            2'd3: w_cc = f_neg_sat(VVs_i);
         endcase
      end else if (w_bu_al) begin
         // Burst sits on the -U axis: -A at phase 0, +A at phase 2.
         unique case (w_ph_al)
            2'd0:    w_cc = -L_BAMP;
            2'd2:    w_cc = L_BAMP;
            default: w_cc = '0;
         endcase
      end
   end

   logic              r_active;
   logic              r_burst;
   logic [1:0]        r_phase;
   logic signed [7:0] r_cc;

   always_ff @(posedge CK_i or posedge AR_i) begin
      if (AR_i) begin
         r_active <= 1'b0;
         r_burst  <= 1'b0;
         r_phase  <= '0;
         r_cc     <= '0;
      end else if (EE_i) begin
         r_active <= w_ac_al;
         r_burst  <= w_bu_al;
         r_phase  <= w_ph_al;
         r_cc     <= w_cc;
      end
   end

   assign HCTRs_o  = r_hctr;
   assign VCTRs_o  = r_vctr;
   assign HSYNC_o  = r_hsync;
   assign VSYNC_o  = r_vsync;
   assign ACTIVE_o = r_active;
   assign BURST_o  = r_burst;
   assign PHASE_o  = r_phase;
   assign CCs_o    = r_cc;

endmodule

// File: tb/tb_ntsc_chroma_seq.sv
// -----------------------------------------------------------------------------
// Bench for ntsc_chroma_seq.  Instance A uses the broadcast parameters; a
// second, shrunken instance B shares the inputs so full frame wraps fit in a
// short run.  The reference describes every output as a function of the
// number n of enabled cycles since reset (plus the U/V history), computed
// with plain division/modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_ntsc_chroma_seq;

   typedef struct packed {
      int ht, vt, hsw, bst, bw, ast, aw, vsst, vsh, vast, vah, pd, amp;
   } cfg_t;

   localparam cfg_t CA = '{910, 525, 67, 76, 36, 140, 768, 3, 3, 20, 480, 2, 20};
   localparam cfg_t CB = '{10, 6, 2, 3, 2, 5, 4, 1, 1, 2, 3, 2, 20};
   localparam int SZ = 32768;

   logic              CK = 1'b0;
   logic              AR;
   logic              EE;
   logic signed [7:0] UU;
   logic signed [7:0] VV;

   logic        [9:0] a_h, a_v, b_h, b_v;
   logic              a_pr, a_hs, a_vs, a_bu, a_ac, b_pr, b_hs, b_vs, b_bu, b_ac;
   logic        [1:0] a_ph, b_ph;
   logic signed [7:0] a_cc, b_cc;

   ntsc_chroma_seq dut_a (
      .CK_i(CK), .AR_i(AR), .EE_i(EE), .UUs_i(UU), .VVs_i(VV),
      .HCTRs_o(a_h), .VCTRs_o(a_v), .PIX_REQ_o(a_pr), .HSYNC_o(a_hs),
      .VSYNC_o(a_vs), .BURST_o(a_bu), .ACTIVE_o(a_ac), .PHASE_o(a_ph),
      .CCs_o(a_cc));

   ntsc_chroma_seq #(
      .C_H_TOTAL(10), .C_V_TOTAL(6), .C_HSYNC_W(2), .C_BURST_ST(3),
      .C_BURST_W(2), .C_ACT_ST(5), .C_ACT_W(4), .C_VSYNC_ST(1),
      .C_VSYNC_H(1), .C_VACT_ST(2), .C_VACT_H(3), .C_PIPE_DLY(2),
      .C_BURST_AMP(20)
   ) dut_b (
      .CK_i(CK), .AR_i(AR), .EE_i(EE), .UUs_i(UU), .VVs_i(VV),
      .HCTRs_o(b_h), .VCTRs_o(b_v), .PIX_REQ_o(b_pr), .HSYNC_o(b_hs),
      .VSYNC_o(b_vs), .BURST_o(b_bu), .ACTIVE_o(b_ac), .PHASE_o(b_ph),
      .CCs_o(b_cc));

   always #5 CK = ~CK;

   int checks = 0;
   int errors = 0;
   int n      = 0;       // enabled cycles since reset release
   int uin[SZ];          // U/V present at the enabled edge leaving state n
   int vin[SZ];

   task automatic chk(input string name, input integer act, input integer exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s n=%0d got %0d want %0d", name, n, act, exp);
      end
   endtask

   // Undelayed timing of enabled-cycle index k.
   function automatic void stage(input cfg_t c, input int k, output int h,
                                 output int v, output int p, output bit hs,
                                 output bit vs, output bit bu, output bit ac);
      h  = k % c.ht;
      v  = (k / c.ht) % c.vt;
      p  = k % 4;
      hs = h < c.hsw;
      vs = v >= c.vsst && v < c.vsst + c.vsh;
      bu = h >= c.bst && h < c.bst + c.bw && !vs;
      ac = h >= c.ast && h < c.ast + c.aw && v >= c.vast && v < c.vast + c.vah;
   endfunction

   function automatic int sneg(input int x);
      return (x == -128) ? 127 : -x;
   endfunction

   function automatic int chroma(input cfg_t c, input bit ac, input bit bu,
                                 input int p, input int u, input int vv);
      if (ac) return (p == 0) ? u : (p == 1) ? vv : (p == 2) ? sneg(u) : sneg(vv);
      if (bu) return (p == 0) ? -c.amp : (p == 2) ? c.amp : 0;
      return 0;
   endfunction

   task automatic check_set(input string t, input cfg_t c, input integer hc,
                            input integer vc, input integer pr, input integer hso,
                            input integer vso, input integer bo, input integer ao,
                            input integer ph, input integer cc);
      int h, v, p, d, eh, ev, eb, ea, ep, ec;
      bit hs, vs, bu, ac;
      eh = 0; ev = 0; eb = 0; ea = 0; ep = 0; ec = 0;
      stage(c, n, h, v, p, hs, vs, bu, ac);
      chk({t, "hctr"}, hc, h);
      chk({t, "vctr"}, vc, v);
      chk({t, "pixreq"}, pr, int'(ac));
      if (n >= 1) begin
         stage(c, n - 1, h, v, p, hs, vs, bu, ac);
         eh = int'(hs);
         ev = int'(vs);
      end
      d = c.pd + 1;
      if (n >= d) begin
         stage(c, n - d, h, v, p, hs, vs, bu, ac);
         ea = int'(ac);
         eb = int'(bu);
         ep = p;
         ec = chroma(c, ac, bu, p, uin[(n - 1) % SZ], vin[(n - 1) % SZ]);
      end
      chk({t, "hsync"}, hso, eh);
      chk({t, "vsync"}, vso, ev);
      chk({t, "burst"}, bo, eb);
      chk({t, "active"}, ao, ea);
      chk({t, "phase"}, ph, ep);
      chk({t, "cc"}, cc, ec);
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge CK) begin
      check_set("A_", CA, a_h, a_v, a_pr, a_hs, a_vs, a_bu, a_ac, a_ph, a_cc);
      check_set("B_", CB, b_h, b_v, b_pr, b_hs, b_vs, b_bu, b_ac, b_ph, b_cc);
      // Hand-computed points that pin the reference itself.
      case (n)
         1:     begin chk("lit_h1", a_h, 1); chk("lit_hs1", a_hs, 1); end
         3:     begin chk("lit_ph3", a_ph, 0); chk("lit_cc3", a_cc, 0); end
         4:           chk("lit_ph4", a_ph, 1);
         59:    begin chk("litB_h59", b_h, 9); chk("litB_v59", b_v, 5); end
         60:    begin chk("litB_h60", b_h, 0); chk("litB_v60", b_v, 0); end
         910:   begin chk("lit_hwrap", a_h, 0); chk("lit_vinc", a_v, 1); end
         913:         chk("lit_ph_line1", a_ph, 2);
         3719:  begin chk("lit_vs_burst", a_bu, 0); chk("lit_vs_cc", a_cc, 0);
                      chk("lit_vs_vsync", a_vs, 1); end
         9179:  begin chk("lit_bu0", a_cc, -20); chk("lit_bu_flag", a_bu, 1); end
         9180:        chk("lit_bu1", a_cc, 0);
         9181:        chk("lit_bu2", a_cc, 20);
         9182:        chk("lit_bu3", a_cc, 0);
         18339:       chk("lit_pr_lo", a_pr, 0);
         18340:       chk("lit_pr_hi", a_pr, 1);
         18342:       chk("lit_act_lo", a_ac, 0);
         18343: begin chk("lit_act_hi", a_ac, 1); chk("lit_cc_u", a_cc, 10); end
         18344:       chk("lit_cc_v", a_cc, -5);
         18345:       chk("lit_cc_nu", a_cc, -10);
         18346:       chk("lit_cc_nv", a_cc, 5);
         18353:       chk("lit_sat_u", a_cc, 127);
         18354:       chk("lit_sat_v", a_cc, 127);
         default: ;
      endcase
   end

   // Drive EE/U/V for the current state n and record what the next edge sees.
   task automatic drive();
      int h, v;
      h = n % CA.ht;
      v = (n / CA.ht) % CA.vt;
      if (n < 1200) EE = !EE;
      else          EE = ($urandom_range(0, 3) != 0);
      if (v == 20 && h >= 142 && h <= 145) begin
         UU = 8'sd10;
         VV = -8'sd5;
      end else if (v == 20 && h >= 150 && h <= 159) begin
         UU = 8'sh80;
         VV = 8'sh80;
      end else begin
         UU = ($urandom_range(0, 7) == 0) ? 8'sh80 : 8'($urandom);
         VV = ($urandom_range(0, 7) == 0) ? 8'sh80 : 8'($urandom);
      end
      uin[n % SZ] = int'(UU);
      vin[n % SZ] = int'(VV);
   endtask

   initial begin
      bit hit;
      AR = 1'b1; EE = 1'b0; UU = '0; VV = '0;
      repeat (3) @(posedge CK);
      #1 AR = 1'b0;

      // Long run through line 21, alternating EE first, then random EE.
      hit = 1'b0;
      for (int i = 0; i < 40000 && !hit; i++) begin
         drive();
         @(posedge CK);
         if (EE) n++;
         #1;
         if (n >= 19300 && (n % CA.ht) == 500) hit = 1'b1;
      end
      chk("reach_h500", int'(hit), 1);

      // Mid-line asynchronous reset: outputs must clear before any edge.
      AR = 1'b1;
      n  = 0;
      #2;
      chk("ar_hctr", a_h, 0);
      chk("ar_vctr", a_v, 0);
      chk("ar_hsync", a_hs, 0);
      chk("ar_active", a_ac, 0);
      chk("ar_phase", a_ph, 0);
      chk("ar_cc", a_cc, 0);
      chk("arB_hctr", b_h, 0);
      repeat (2) @(posedge CK);
      #1 AR = 1'b0;

      // Restart from (0,0), phase 0; instance B wraps many frames here.
      for (int i = 0; i < 3000; i++) begin
         drive();
         @(posedge CK);
         if (EE) n++;
         #1;
      end
      @(negedge CK);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ntsc_chroma_seq.md
Name: ntsc_chroma_seq

Overview:
- 4fsc NTSC timing and chroma-modulation sequencer.
- Free-runs H/V sample counters, generates sync, burst and active flags, and tracks the 4-phase subcarrier index.
- Muxes the signed U/V samples from the RGB-to-YUV converter into a quadrature-modulated chroma sample, with colour burst inserted.
- Sits between the pixel source/converter and the DAC composite summer.

Parameters:
C_H_TOTAL, 910, samples per line (counter wraps at C_H_TOTAL-1)
C_V_TOTAL, 525, lines per frame
C_HSYNC_W, 67, HSYNC width in samples from HCTR=0
C_BURST_ST, 76, first burst sample
C_BURST_W, 36, burst length in samples
C_ACT_ST, 140, first active sample
C_ACT_W, 768, active samples per line
C_VSYNC_ST, 3, first VSYNC line
C_VSYNC_H, 3, VSYNC lines
C_VACT_ST, 20, first active line
C_VACT_H, 480, active lines
C_PIPE_DLY, 2, converter latency in enabled cycles
C_BURST_AMP, 20, burst amplitude (signed 8-bit magnitude)

Ports:
CK_i  in  1  clock, 4fsc (14.318 MHz)
AR_i  in  1  asynchronous reset, active-high
EE_i  in  1  clock enable; all state advances only when 1
UUs_i  in  8  signed U from converter
VVs_i  in  8  signed V from converter
HCTRs_o  out  10  horizontal sample counter
VCTRs_o  out  10  line counter
PIX_REQ_o  out  1  request RGB pixel to converter (undelayed active)
HSYNC_o  out  1  horizontal sync, active-high
VSYNC_o  out  1  vertical sync, active-high
BURST_o  out  1  burst window, aligned with CCs_o
ACTIVE_o  out  1  active video, aligned with CCs_o
PHASE_o  out  2  subcarrier phase aligned with CCs_o (0:+U 1:+V 2:-U 3:-V)
CCs_o  out  8  signed modulated chroma

Behaviour:
- Reset (AR_i=1, asynchronous): every register and output = 0. This includes HCTR, VCTR, phase counter, delay lines and CCs_o.
- With EE_i=0, all registers hold. The delay lines count enabled cycles, not clocks.
- HCTR: +1 per enabled cycle; at C_H_TOTAL-1 wraps to 0.
- VCTR: +1 on the same cycle HCTR wraps; wraps to 0 at C_V_TOTAL-1. A simultaneous H and V wrap yields (0,0).
- Phase counter: 2-bit, +1 every enabled cycle, never reset by line/frame wrap. 910 mod 4 = 2 gives the NTSC 180° line-to-line inversion naturally.
- Undelayed (stage-0) flags:
  - hs = HCTR < C_HSYNC_W
  - vs = VCTR in [C_VSYNC_ST, C_VSYNC_ST+C_VSYNC_H)
  - bu = HCTR in [C_BURST_ST, C_BURST_ST+C_BURST_W) and not vs
  - ac = HCTR in [C_ACT_ST, C_ACT_ST+C_ACT_W) and VCTR in [C_VACT_ST, C_VACT_ST+C_VACT_H)
- PIX_REQ_o = ac, combinational from registered counters.
- HSYNC_o, VSYNC_o: registered, 1 cycle after counters; no further delay.
- ac, bu and phase enter a C_PIPE_DLY-stage shift register (advancing on EE_i) to align with UUs_i/VVs_i. One more register stage produces ACTIVE_o, BURST_o, PHASE_o and CCs_o together.
- Total latency from PIX_REQ_o to CCs_o: C_PIPE_DLY+1 enabled cycles.
- CCs_o selection, using delayed phase p:
  - active: p=0 → U; p=1 → V; p=2 → −U; p=3 → −V.
  - burst (the −U axis): p=0 → −C_BURST_AMP; p=2 → +C_BURST_AMP; p=1,3 → 0.
  - neither: 0. Active and burst never overlap under legal parameters; if they do, active has priority.
- Negation saturates: −(−128) = +127. No other overflow is possible.
- AR_i asserted mid-line: immediate return to reset values; counting restarts from (0,0), phase 0, on the first enabled cycle after release.

Test Plan:
- Reset, then EE_i=1 for 4 cycles → HCTRs_o 0,1,2,3; PHASE_o 0 until the pipeline fills; CCs_o=0; HSYNC_o=1 from cycle 1.
- Run to HCTR=909 → next HCTR=0, VCTR+1. Then VCTR=524/HCTR=909 → (0,0). Phase at HCTR=0 of line n+1 differs from line n by 2.
- Line 20, HCTR 140..143 with UUs_i=10, VVs_i=−5 → CCs_o = 10, −5, −10, 5 (rotated per start phase); ACTIVE_o=1 exactly C_PIPE_DLY+1 cycles after PIX_REQ_o rises.
- Burst on line 10 → CCs_o cycles through −20, 0, +20, 0 over samples 76..111 with BURST_o=1. On VSYNC lines 3..5 → BURST_o=0, CCs_o=0.
- UUs_i=−128 at phase 2 → CCs_o=+127; VVs_i=−128 at phase 3 → +127.
- Toggle EE_i 1/0 alternately → counters advance on enabled cycles only, alignment preserved. Assert AR_i at HCTR=500 → all outputs 0 asynchronously.
